i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (slave) block: the bus-side counterpart of the existing I2C master. It watches the Scl and Sda lines and answers its own 7-bit address with open-drain ACKs. On writes it captures a pointer byte plus a two-byte data word; on reads it returns a 16-bit word supplied by the host logic. It sits beside the master on the same Scl/Sda wires, as the bus endpoint used to close the loop in system simulation.

## Interface
- SLV_ADDR, 7'h48, 7-bit bus address this target responds to
- SYNC_STAGES, 2, synchronizer depth on Scl/Sda inputs (min 2)
- Clk  in  1  system clock; only clock of the block; must be ≥ 8× Scl frequency
- Rst  in  1  reset, asynchronous, active-low
- Scl  in  1  bus clock as seen on the wire (never driven; no clock stretching)
- Sda_in  in  1  bus data as seen on the wire
- Sda_oe  out  1  1 = pull Sda low (top level ties pin via bufif1 to Gnd); 0 = release
- Rd_data  in  16  word returned on reads; sampled once per read byte-pair
- Pointer  out  8  last pointer byte written by the master
- Wr_data  out  16  {data1, data2} of last complete write
- Wr_valid  out  1  one-Clk pulse when Wr_data updates
- Busy  out  1  high from an addressed START until STOP or mismatch
- Error  out  1  one-Clk pulse on protocol fault (see Operation)

## Operation
- Scl/Sda pass through SYNC_STAGES flops, then a one-flop edge detector. START = Sda fall while Scl high; STOP = Sda rise while Scl high.
- Data is sampled on Scl rise. Sda_oe changes only on Scl fall.
- States: IDLE, ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_D1, ACK_D1, RX_D2, ACK_D2, TX_BYTE, RX_MACK, IGNORE.
- A 3-bit bit counter is used for all byte states. MSB is first.
- ADDR: shift 8 bits. If {SLV_ADDR} matches bits[7:1], go to ACK_ADDR, drive ACK (Sda_oe=1 for one Scl low+high period), and set Busy. On mismatch, go to IGNORE with no ACK.
- Write (R/W=0): ACK_ADDR→RX_PTR→ACK_PTR (Pointer updates at this ACK)→RX_D1→ACK_D1→RX_D2→ACK_D2. At ACK_D2, Wr_data and Wr_valid update, then the next state is RX_D1 (further byte pairs overwrite).
- Read (R/W=1): at ACK_ADDR, latch Rd_data into a 16-bit tx register. TX_BYTE drives bit=0 as Sda_oe=1 and releases on bit=1. Send the high byte, then RX_MACK. On master ACK, send the low byte, then RX_MACK again. On master ACK after the low byte, relatch Rd_data and wrap to the high byte. On master NACK, release Sda and go to IGNORE.
- START in any state (repeated start): go to ADDR, reset the bit counter, release Sda. Pointer is kept.
- STOP in any state: go to IDLE, release Sda, clear Busy.
- Error pulse conditions:
  - STOP or START arrives while in RX_D2 or ACK_D1, i.e. a write ends with an odd data byte. The partial word is discarded.
  - Sda changes while Scl is high inside a byte state in a way that is neither START nor STOP. This cannot occur in practice: such a change is by definition START/STOP and handled as above.
- IGNORE: wait for START or STOP only.

## Timing
- Reset values: Sda_oe=0, Pointer=8'h00, Wr_data=16'h0000, Wr_valid=0, Busy=0, Error=0, state IDLE, tx register 0.
- Event latency: SYNC_STAGES+1 Clk from pin edge to internal event.
- Sda_oe updates 1 Clk after the internal Scl-fall event, i.e. SYNC_STAGES+2 Clk after the pin edge. This is well inside Scl low at the ≥8× ratio.
- Wr_valid and Pointer update in the Clk following the Scl fall that begins the corresponding ACK bit.
- Rst asserted mid-transfer releases Sda immediately (asynchronously). Deassertion returns the block to IDLE; it resumes only at the next START.

## Structure
- Package i2c_pkg: state enumeration, ACK/NACK constants (ACK=1'b0), R/W bit position, default SLV_ADDR.
- Sub-module i2c_bus_monitor: synchronizers plus Scl rise/fall, START and STOP pulse generation. It is reusable by the master for arbitration later.
- Top i2c_slave: FSM, bit counter, rx shift register, tx shift register, output registers.

## Test plan
- Write 0x90, 0x01, 0xAB, 0xCD, STOP → three ACKs by the slave plus the data ACK; Pointer=0x01; Wr_data=0xABCD; one Wr_valid pulse.
- Write to 0x50 (address mismatch) → Sda_oe stays 0 for the whole transfer; Busy stays 0; outputs unchanged.
- Write 0x90, 0x02, repeated START, 0x91, Rd_data=0x1234, master ACK then NACK → bytes 0x12, 0x34 on Sda; Pointer=0x02; slave in IGNORE; Busy drops at STOP.
- Read with 3 master ACKs, Rd_data changed to 0x5678 after the first pair → bytes 0x12, 0x34, 0x56, 0x78.
- Write 0x90, 0x03, 0xEE, STOP → one Error pulse; Wr_valid never asserts; Wr_data unchanged.
- Assert Rst during the 5th bit of a TX_BYTE that is driving 0 → Sda_oe=0 within the same Clk; after release, the slave ignores traffic until a new START.

Source files
------------

// File: rtl/i2c_pkg.sv
// I2C target shared definitions: FSM state codes,
// ACK/NACK levels, R/W bit position, default address.
package i2c_pkg;
  localparam logic [6:0] SLV_ADDR_DEF = 7'h48;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int RW_BIT = 0;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ADDR = 4'd1;
  localparam logic [3:0] S_ACK_ADDR = 4'd2;
  localparam logic [3:0] S_RX_PTR = 4'd3;
  localparam logic [3:0] S_ACK_PTR = 4'd4;
  localparam logic [3:0] S_RX_D1 = 4'd5;
  localparam logic [3:0] S_ACK_D1 = 4'd6;
  localparam logic [3:0] S_RX_D2 = 4'd7;
  localparam logic [3:0] S_ACK_D2 = 4'd8;
  localparam logic [3:0] S_TX_BYTE = 4'd9;
  localparam logic [3:0] S_RX_MACK = 4'd10;
  localparam logic [3:0] S_IGNORE = 4'd11;
endpackage

// File: rtl/i2c_slave_if.sv
// I2C wire bundle: Scl, Sda as seen on the wire, and
// the target's open-drain pull-down enable.
interface i2c_slave_if;
  logic Scl;
  logic Sda_in;
  logic Sda_oe;

  modport master (
    output Scl,
    output Sda_in,
    input  Sda_oe
  );

  modport slave (
    input  Scl,
    input  Sda_in,
    output Sda_oe
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Scl/Sda synchronizers plus registered Scl rise/fall,
// START/STOP pulses and the Sda sample aligned to them.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_s, sda_s;
  logic scl_q, sda_q;
  logic rise_q, fall_q, start_q, stop_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Idle bus is high, so reset to 1 to avoid false events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      start_q <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_q <= scl_s;
      sda_q <= sda_s;
      rise_q <= scl_s & ~scl_q;
      fall_q <= ~scl_s & scl_q;
      start_q <= scl_s & scl_q & sda_q & ~sda_s;
      stop_q <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign start_o = start_q;
  assign stop_o = stop_q;
  assign sda_o = sda_q;
endmodule

// File: rtl/i2c_slave.sv
// I2C target: ACKs SLV_ADDR, captures pointer + 16-bit
// writes, returns Rd_data on reads. Ports: Clk, Rst,
// bus (Scl/Sda_in/Sda_oe), Rd_data, Pointer, Wr_data,
// Wr_valid, Busy, Error.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR = SLV_ADDR_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  i2c_slave_if.slave  bus,
  input  logic [15:0] Rd_data,
  output logic [7:0]  Pointer,
  output logic [15:0] Wr_data,
  output logic        Wr_valid,
  output logic        Busy,
  output logic        Error
);
  logic rise_ev, fall_ev, start_ev, stop_ev, sda_s;
  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic [7:0] sh_q, sh_d, d1_q, d1_d, ptr_q, ptr_d;
  logic [15:0] tx_q, tx_d, wd_q, wd_d;
  logic lo_q, lo_d, rw_q, rw_d, oe_q, oe_d;
  logic busy_q, busy_d, wv_q, wv_d, err_q, err_d;
  logic byte_st, odd_st;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk(Clk),
    .rst_n(Rst),
    .scl_i(bus.Scl),
    .sda_i(bus.Sda_in),
    .scl_rise_o(rise_ev),
    .scl_fall_o(fall_ev),
    .start_o(start_ev),
    .stop_o(stop_ev),
    .sda_o(sda_s)
  );

  assign byte_st = state_q inside
    {S_ADDR, S_RX_PTR, S_RX_D1, S_RX_D2, S_TX_BYTE};
  // A write ending here holds an unpaired data byte.
  assign odd_st = (state_q == S_RX_D2) ||
                  (state_q == S_ACK_D1);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = done_q;
    sh_d = sh_q;
    d1_d = d1_q;
    tx_d = tx_q;
    lo_d = lo_q;
    rw_d = rw_q;
    oe_d = oe_q;
    ptr_d = ptr_q;
    wd_d = wd_q;
    busy_d = busy_q;
    wv_d = 1'b0;
    err_d = 1'b0;
    unique case (1'b1)
      start_ev: begin
        err_d = odd_st;
        state_d = S_ADDR;
        cnt_d = '0;
        done_d = 1'b0;
        oe_d = 1'b0;
      end
      stop_ev: begin
        err_d = odd_st;
        state_d = S_IDLE;
        oe_d = 1'b0;
        busy_d = 1'b0;
      end
      rise_ev: begin
        if (byte_st) begin
          sh_d = {sh_q[6:0], sda_s};
          cnt_d = cnt_q + 3'd1;
          done_d = (cnt_q == 3'd7);
        end
        if (state_q == S_RX_MACK && sda_s == NACK)
          state_d = S_IGNORE;
      end
      fall_ev: begin
        case (state_q)
          S_ADDR: if (done_q) begin
            if (sh_q[7:1] == SLV_ADDR) begin
              state_d = S_ACK_ADDR;
              oe_d = 1'b1;
              busy_d = 1'b1;
              rw_d = sh_q[RW_BIT];
              if (sh_q[RW_BIT]) tx_d = Rd_data;
            end else begin
              state_d = S_IGNORE;
              busy_d = 1'b0;
            end
          end
          S_ACK_ADDR: begin
            cnt_d = '0;
            done_d = 1'b0;
            if (rw_q) begin
              state_d = S_TX_BYTE;
              oe_d = ~tx_q[15];
              tx_d = {tx_q[14:0], 1'b0};
              lo_d = 1'b0;
            end else begin
              state_d = S_RX_PTR;
              oe_d = 1'b0;
            end
          end
          S_RX_PTR: if (done_q) begin
            state_d = S_ACK_PTR;
            oe_d = 1'b1;
            ptr_d = sh_q;
          end
          S_RX_D1: if (done_q) begin
            state_d = S_ACK_D1;
            oe_d = 1'b1;
            d1_d = sh_q;
          end
          S_RX_D2: if (done_q) begin
            state_d = S_ACK_D2;
            oe_d = 1'b1;
            wd_d = {d1_q, sh_q};
            wv_d = 1'b1;
          end
          S_ACK_PTR, S_ACK_D2: begin
            state_d = S_RX_D1;
            oe_d = 1'b0;
            cnt_d = '0;
            done_d = 1'b0;
          end
          S_ACK_D1: begin
            state_d = S_RX_D2;
            oe_d = 1'b0;
            cnt_d = '0;
            done_d = 1'b0;
          end
          S_TX_BYTE: begin
            if (done_q) begin
              state_d = S_RX_MACK;
              oe_d = 1'b0;
            end else begin
              oe_d = ~tx_q[15];
              tx_d = {tx_q[14:0], 1'b0};
            end
          end
          // Only reached after a master ACK; NACK left on rise.
          S_RX_MACK: begin
            state_d = S_TX_BYTE;
            cnt_d = '0;
            done_d = 1'b0;
            lo_d = ~lo_q;
            if (lo_q) begin
              oe_d = ~Rd_data[15];
              tx_d = {Rd_data[14:0], 1'b0};
            end else begin
              oe_d = ~tx_q[15];
              tx_d = {tx_q[14:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      sh_q <= '0;
      d1_q <= '0;
      tx_q <= '0;
      lo_q <= 1'b0;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      ptr_q <= '0;
      wd_q <= '0;
      busy_q <= 1'b0;
      wv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      sh_q <= sh_d;
      d1_q <= d1_d;
      tx_q <= tx_d;
      lo_q <= lo_d;
      rw_q <= rw_d;
      oe_q <= oe_d;
      ptr_q <= ptr_d;
      wd_q <= wd_d;
      busy_q <= busy_d;
      wv_q <= wv_d;
      err_q <= err_d;
    end
  end

  assign bus.Sda_oe = oe_q;
  assign Pointer = ptr_q;
  assign Wr_data = wd_q;
  assign Wr_valid = wv_q;
  assign Busy = busy_q;
  assign Error = err_q;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master on
// an open-drain wire, hand-computed expectations.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 50;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [15:0] rd_data = 16'h1234;
  logic [7:0] ptr;
  logic [15:0] wdat;
  logic wv, busy, err;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int err_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int wv0, err0, oe0, busy0;
  logic ack, s;
  logic [7:0] rb;

  i2c_slave_if bus ();
  assign bus.Scl = scl_m;
  assign bus.Sda_in = sda_m & ~bus.Sda_oe;

  i2c_slave dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus),
    .Rd_data(rd_data),
    .Pointer(ptr),
    .Wr_data(wdat),
    .Wr_valid(wv),
    .Busy(busy),
    .Error(err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    wv_cnt <= wv_cnt + (wv ? 1 : 0);
    err_cnt <= err_cnt + (err ? 1 : 0);
    oe_cnt <= oe_cnt + (bus.Sda_oe ? 1 : 0);
    busy_cnt <= busy_cnt + (busy ? 1 : 0);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wbit(input logic b, output logic smp);
    sda_m = b;
    #Q scl_m = 1'b1;
    #Q smp = bus.Sda_in;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic a);
    logic x;
    for (int i = 7; i >= 0; i--) wbit(d[i], x);
    wbit(1'b1, a);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      wbit(1'b1, x);
      d[i] = x;
    end
    wbit(mack, x);
  endtask

  task automatic start_c;
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic stop_c;
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic snap;
    wv0 = wv_cnt;
    err0 = err_cnt;
    oe0 = oe_cnt;
    busy0 = busy_cnt;
  endtask

  initial begin
    #23;
    chk("rst_oe", bus.Sda_oe, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_wd", wdat, 0);
    chk("rst_wv", wv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    Rst = 1'b1;
    #100;

    // Plain write 0x90 01 AB CD
    snap();
    start_c();
    wbyte(8'h90, ack); chk("w_aack", ack, ACK);
    wbyte(8'h01, ack); chk("w_pack", ack, ACK);
    wbyte(8'hAB, ack); chk("w_d1ack", ack, ACK);
    wbyte(8'hCD, ack); chk("w_d2ack", ack, ACK);
    chk("w_busy", busy, 1);
    stop_c();
    chk("w_ptr", ptr, 8'h01);
    chk("w_wd", wdat, 16'hABCD);
    chk("w_wvn", wv_cnt - wv0, 1);
    chk("w_errn", err_cnt - err0, 0);
    chk("w_idle", busy, 0);

    // Address 0x50 is not ours
    snap();
    start_c();
    wbyte(8'hA0, ack); chk("m_aack", ack, NACK);
    wbyte(8'h77, ack); chk("m_dack", ack, NACK);
    stop_c();
    chk("m_oe", oe_cnt - oe0, 0);
    chk("m_busy", busy_cnt - busy0, 0);
    chk("m_ptr", ptr, 8'h01);
    chk("m_wd", wdat, 16'hABCD);

    // Pointer write, repeated START, read 2 bytes
    snap();
    rd_data = 16'h1234;
    start_c();
    wbyte(8'h90, ack); chk("r_aack", ack, ACK);
    wbyte(8'h02, ack); chk("r_pack", ack, ACK);
    start_c();
    wbyte(8'h91, ack); chk("r_rack", ack, ACK);
    rbyte(ACK, rb); chk("r_b0", rb, 8'h12);
    rbyte(NACK, rb); chk("r_b1", rb, 8'h34);
    chk("r_ptr", ptr, 8'h02);
    chk("r_ign", dut.state_q, S_IGNORE);
    chk("r_busy", busy, 1);
    stop_c();
    chk("r_idle", busy, 0);
    chk("r_errn", err_cnt - err0, 0);

    // Four-byte read, data relatched after first pair
    rd_data = 16'h1234;
    start_c();
    wbyte(8'h91, ack); chk("l_aack", ack, ACK);
    rbyte(ACK, rb); chk("l_b0", rb, 8'h12);
    rd_data = 16'h5678;
    rbyte(ACK, rb); chk("l_b1", rb, 8'h34);
    rbyte(ACK, rb); chk("l_b2", rb, 8'h56);
    rbyte(NACK, rb); chk("l_b3", rb, 8'h78);
    stop_c();

    // Odd data byte: error, no write
    snap();
    start_c();
    wbyte(8'h90, ack);
    wbyte(8'h03, ack);
    wbyte(8'hEE, ack); chk("o_dack", ack, ACK);
    stop_c();
    chk("o_errn", err_cnt - err0, 1);
    chk("o_wvn", wv_cnt - wv0, 0);
    chk("o_wd", wdat, 16'hABCD);
    chk("o_ptr", ptr, 8'h03);

    // Reset while driving bit 5 (0) of 0x12
    rd_data = 16'h1234;
    start_c();
    wbyte(8'h91, ack); chk("x_aack", ack, ACK);
    for (int i = 0; i < 4; i++) wbit(1'b1, s);
    chk("x_drv", bus.Sda_oe, 1);
    #3 Rst = 1'b0;
    #1 chk("x_oe", bus.Sda_oe, 0);
    chk("x_ptr", ptr, 0);
    #20 Rst = 1'b1;
    snap();
    for (int i = 0; i < 4; i++) wbit(1'b1, s);
    wbit(NACK, s);
    chk("x_oen", oe_cnt - oe0, 0);
    chk("x_bsy", busy_cnt - busy0, 0);
    chk("x_st", dut.state_q, S_IDLE);
    stop_c();
    snap();
    start_c();
    wbyte(8'h90, ack); chk("y_aack", ack, ACK);
    wbyte(8'h04, ack);
    wbyte(8'h11, ack);
    wbyte(8'h22, ack); chk("y_d2ack", ack, ACK);
    stop_c();
    chk("y_ptr", ptr, 8'h04);
    chk("y_wd", wdat, 16'h1122);
    chk("y_wvn", wv_cnt - wv0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
